// File: rtl/ac_drip_monitor.sv
// ac_drip_monitor: condensate tank level tracker with a timed drain sequence.
// Each cooling step adds one unit to the tank, and the level saturates at all-ones.
// A drain request in IDLE empties the tank at one unit per DRAIN_DIV cycles and
// then emits a one-cycle drain_done pulse.
// Optional feature: define DRIP_ALARM_EN to get a sticky alarm that sets when a
// drop is lost because the tank is full.
module ac_drip_monitor #(
  parameter int unsigned LEVEL_W     = 4,
  parameter int unsigned DRIP_THRESH = 12,
  parameter int unsigned DRAIN_DIV   = 4
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic               step_valid,
  input  logic               step_down,
  input  logic               drain_req,
  output logic [LEVEL_W-1:0] level,
  output logic               pingando,
  output logic               full,
  output logic               cool_inhibit,
  output logic               draining,
  output logic               drain_done,
  output logic               alarm
);

  localparam logic [LEVEL_W-1:0] LVL_MAX  = '1;
  localparam logic [LEVEL_W-1:0] THRESH   = LEVEL_W'(DRIP_THRESH);
  localparam logic [7:0]         DIV_LAST = 8'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DRAINING, DONE} state_t;

  state_t             state;
  logic [7:0]         div_cnt;
  logic [LEVEL_W-1:0] next_level;
  logic               drop;
  logic               accept;
  logic               tick;

  assign drop   = step_valid & step_down;
  assign accept = drop & ~full;
  assign tick   = (state == DRAINING) && (div_cnt == DIV_LAST);

  assign full         = (level == LVL_MAX);
  assign cool_inhibit = full;
  assign pingando     = (level >= THRESH);
  assign draining     = (state == DRAINING);

  // Next level: an accepted drop and a drain tick on the same edge cancel out.
  always_comb begin
    next_level = level;
    unique case ({accept, tick})
      2'b10:   next_level = level + 1'b1;
      2'b01:   next_level = level - 1'b1;
      default: next_level = level;
    endcase
  end

  // Drain FSM, level register, drain divider and the drain_done pulse.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      level      <= '0;
      div_cnt    <= '0;
      drain_done <= 1'b0;
    end else begin
      level      <= next_level;
      drain_done <= 1'b0;
      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          if (drain_req && (level != '0)) begin
            state <= DRAINING;
          end
        end
        DRAINING: begin
          div_cnt <= tick ? '0 : div_cnt + 8'd1;
          if (next_level == '0) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          div_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRIP_ALARM_EN
  // Sticky overflow alarm: only reset clears it.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (drop && full) begin
      alarm <= 1'b1;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_ac_drip_monitor.sv
// Directed bench for ac_drip_monitor. Inputs change and outputs are sampled on
// the falling edge of clk_2.
module tb_ac_drip_monitor;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       step_valid = 1'b0;
  logic       step_down = 1'b0;
  logic       drain_req = 1'b0;
  logic [3:0] level;
  logic       pingando, full, cool_inhibit, draining, drain_done, alarm;

  int unsigned pass_cnt = 0;
  int unsigned total = 0;

`ifdef DRIP_ALARM_EN
  localparam logic ALARM_EXP = 1'b1;
`else
  localparam logic ALARM_EXP = 1'b0;
`endif

  ac_drip_monitor #(.LEVEL_W(4), .DRIP_THRESH(12), .DRAIN_DIV(4)) dut (
    .clk_2(clk_2), .reset(reset), .step_valid(step_valid), .step_down(step_down),
    .drain_req(drain_req), .level(level), .pingando(pingando), .full(full),
    .cool_inhibit(cool_inhibit), .draining(draining), .drain_done(drain_done),
    .alarm(alarm)
  );

  always #5 clk_2 = ~clk_2;

  task automatic do_reset();
    @(negedge clk_2);
    step_valid = 1'b0; step_down = 1'b0; drain_req = 1'b0;
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic steps(input int n, input logic down);
    if (n > 0) begin
      step_valid = 1'b1; step_down = down;
      repeat (n) @(negedge clk_2);
      step_valid = 1'b0; step_down = 1'b0;
    end
  endtask

  task automatic pulse_drain();
    drain_req = 1'b1;
    @(negedge clk_2);
    drain_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++;
    if ({level, pingando, full, draining, drain_done, alarm} !== 9'b0)
      $display("FAIL reset_state: got lvl=%0d p=%b f=%b dr=%b dd=%b al=%b, want all 0",
               level, pingando, full, draining, drain_done, alarm);
    else pass_cnt++;
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic test_drops();
    do_reset();
    steps(11, 1'b1);
    total++;
    if (level !== 4'd11 || pingando !== 1'b0)
      $display("FAIL drops_11: got lvl=%0d p=%b, want 11 0", level, pingando);
    else pass_cnt++;
    steps(1, 1'b1);
    total++;
    if (level !== 4'd12 || pingando !== 1'b1)
      $display("FAIL drops_12: got lvl=%0d p=%b, want 12 1", level, pingando);
    else pass_cnt++;
  endtask

  task automatic test_heating();
    do_reset();
    steps(5, 1'b0);
    total++;
    if (level !== 4'd0)
      $display("FAIL heating: got lvl=%0d, want 0", level);
    else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    steps(15, 1'b1);
    total++;
    if (level !== 4'd15 || full !== 1'b1 || cool_inhibit !== 1'b1 || alarm !== 1'b0)
      $display("FAIL full_15: got lvl=%0d f=%b ci=%b al=%b, want 15 1 1 0",
               level, full, cool_inhibit, alarm);
    else pass_cnt++;
    steps(1, 1'b1);
    total++;
    if (level !== 4'd15 || alarm !== ALARM_EXP)
      $display("FAIL full_16: got lvl=%0d al=%b, want 15 %b", level, alarm, ALARM_EXP);
    else pass_cnt++;
    steps(1, 1'b1);
    total++;
    if (level !== 4'd15 || full !== 1'b1 || alarm !== ALARM_EXP)
      $display("FAIL full_17: got lvl=%0d f=%b al=%b, want 15 1 %b", level, full, alarm, ALARM_EXP);
    else pass_cnt++;
    // draining must not clear the alarm
    pulse_drain();
    repeat (70) @(negedge clk_2);
    total++;
    if (level !== 4'd0 || alarm !== ALARM_EXP)
      $display("FAIL alarm_after_drain: got lvl=%0d al=%b, want 0 %b", level, alarm, ALARM_EXP);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    int cnt;
    do_reset();
    steps(3, 1'b1);
    pulse_drain();
    cnt = 0;
    while (draining === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 4) begin
        total++;
        if (level !== 4'd3) $display("FAIL drain_lvl_c4: got %0d, want 3", level);
        else pass_cnt++;
      end
      if (cnt == 5) begin
        total++;
        if (level !== 4'd2) $display("FAIL drain_lvl_c5: got %0d, want 2", level);
        else pass_cnt++;
      end
      if (cnt == 9) begin
        total++;
        if (level !== 4'd1) $display("FAIL drain_lvl_c9: got %0d, want 1", level);
        else pass_cnt++;
      end
      @(negedge clk_2);
    end
    total++;
    if (cnt != 12) $display("FAIL drain_len: got %0d cycles, want 12", cnt);
    else pass_cnt++;
    total++;
    if (drain_done !== 1'b1 || level !== 4'd0)
      $display("FAIL drain_done_pulse: got dd=%b lvl=%0d, want 1 0", drain_done, level);
    else pass_cnt++;
    @(negedge clk_2);
    total++;
    if (drain_done !== 1'b0 || draining !== 1'b0)
      $display("FAIL drain_idle: got dd=%b dr=%b, want 0 0", drain_done, draining);
    else pass_cnt++;
  endtask

  task automatic test_drop_on_tick();
    int cnt;
    do_reset();
    steps(3, 1'b1);
    pulse_drain();
    cnt = 0;
    while (draining === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 4) begin step_valid = 1'b1; step_down = 1'b1; end
      if (cnt == 5) begin
        step_valid = 1'b0; step_down = 1'b0;
        total++;
        if (level !== 4'd3) $display("FAIL tick_net_zero: got %0d, want 3", level);
        else pass_cnt++;
      end
      @(negedge clk_2);
    end
    total++;
    if (cnt != 16 || drain_done !== 1'b1)
      $display("FAIL tick_drain_len: got %0d cycles dd=%b, want 16 1", cnt, drain_done);
    else pass_cnt++;
  endtask

  task automatic test_req_ignored();
    do_reset();
    pulse_drain();
    total++;
    if (draining !== 1'b0) $display("FAIL req_at_zero: got dr=%b, want 0", draining);
    else pass_cnt++;
    // request held through DONE with an empty tank
    steps(1, 1'b1);
    drain_req = 1'b1;
    repeat (7) @(negedge clk_2);
    total++;
    if (draining !== 1'b0 || level !== 4'd0 || drain_done !== 1'b0)
      $display("FAIL req_held: got dr=%b lvl=%0d dd=%b, want 0 0 0", draining, level, drain_done);
    else pass_cnt++;
    drain_req = 1'b0;
  endtask

  task automatic test_done_drop();
    int cnt;
    do_reset();
    steps(1, 1'b1);
    pulse_drain();
    cnt = 0;
    while (drain_done !== 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk_2);
    end
    step_valid = 1'b1; step_down = 1'b1;
    @(negedge clk_2);
    step_valid = 1'b0; step_down = 1'b0;
    total++;
    if (cnt != 4 || level !== 4'd1 || draining !== 1'b0)
      $display("FAIL done_drop: got cyc=%0d lvl=%0d dr=%b, want 4 1 0", cnt, level, draining);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    do_reset();
    steps(6, 1'b1);
    pulse_drain();
    repeat (3) @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    total++;
    if (level !== 4'd0 || draining !== 1'b0 || alarm !== 1'b0)
      $display("FAIL reset_mid_drain: got lvl=%0d dr=%b al=%b, want 0 0 0", level, draining, alarm);
    else pass_cnt++;
    @(negedge clk_2);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk_2);
      if (drain_done === 1'b1 || draining === 1'b1) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL no_done_after_reset: got %0d active cycles, want 0", seen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_drops();
    test_heating();
    test_full();
    test_drain();
    test_drop_on_tick();
    test_req_ignored();
    test_done_drop();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
